// File: rtl/kv_cache_sched_if.sv
// rtl/kv_cache_sched_if.sv - append and scan-output stream bundle for kv_cache_sched
interface kv_cache_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  append_valid;
  logic                  append_ready;
  logic [DATA_WIDTH-1:0] append_k;
  logic [DATA_WIDTH-1:0] append_v;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_k;
  logic [DATA_WIDTH-1:0] out_v;
  logic [ADDR_W-1:0]     out_idx;
  logic                  out_last;

  modport master (
    output append_valid, append_k, append_v,
    input  append_ready,
    input  out_valid, out_k, out_v, out_idx, out_last,
    output out_ready
  );

  modport slave (
    input  append_valid, append_k, append_v,
    output append_ready,
    output out_valid, out_k, out_v, out_idx, out_last,
    input  out_ready
  );
endinterface

// File: rtl/kv_cache_sched.sv
// rtl/kv_cache_sched.sv - append/scan sequencer for one kv_cache instance
// Appends one token per cycle; scans a length snapshot through a 2-entry skid FIFO.
module kv_cache_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic [ADDR_W:0]       seq_len,
  output logic                  full,
  output logic                  mem_wr_en,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_k_wr,
  output logic [DATA_WIDTH-1:0] mem_v_wr,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_k_rd,
  input  logic [DATA_WIDTH-1:0] mem_v_rd,
  kv_cache_sched_if.slave       bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_W:0]       seq_len_q, seq_len_d;
  logic [ADDR_W:0]       snap_q, snap_d;
  logic [ADDR_W:0]       rd_idx_q, rd_idx_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_W-1:0]     inflight_idx_q, inflight_idx_d;
  logic [DATA_WIDTH-1:0] fifo_k_q [2];
  logic [DATA_WIDTH-1:0] fifo_k_d [2];
  logic [DATA_WIDTH-1:0] fifo_v_q [2];
  logic [DATA_WIDTH-1:0] fifo_v_d [2];
  logic [ADDR_W-1:0]     fifo_idx_q [2];
  logic [ADDR_W-1:0]     fifo_idx_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  append_fire;
  logic                  pop;
  logic                  push;
  logic                  rd_issue;
  logic [1:0]            occ_after_pop;

  always_comb begin
    full             = (seq_len_q == LEN_FULL);
    seq_len          = seq_len_q;
    scan_busy        = (state_q != ST_IDLE);
    scan_done        = (state_q == ST_DONE);
    bus.append_ready = !full;
    append_fire      = bus.append_valid && !full && !clear;

    bus.out_valid = (cnt_q != 2'd0);
    bus.out_k     = bus.out_valid ? fifo_k_q[rd_ptr_q]   : '0;
    bus.out_v     = bus.out_valid ? fifo_v_q[rd_ptr_q]   : '0;
    bus.out_idx   = bus.out_valid ? fifo_idx_q[rd_ptr_q] : '0;
    bus.out_last  = bus.out_valid && ({1'b0, fifo_idx_q[rd_ptr_q]} == (snap_q - LEN_ONE));

    pop  = bus.out_valid && bus.out_ready;
    push = inflight_q;
    // Issue only if the data returning next cycle is guaranteed a free FIFO slot.
    occ_after_pop = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
    rd_issue      = (state_q == ST_SCAN) && !clear && (rd_idx_q < snap_q) && (occ_after_pop < 2'd2);

    mem_wr_en   = append_fire;
    mem_wr_addr = append_fire ? seq_len_q[ADDR_W-1:0] : '0;
    mem_k_wr    = append_fire ? bus.append_k : '0;
    mem_v_wr    = append_fire ? bus.append_v : '0;
    mem_rd_en   = rd_issue;
    mem_rd_addr = rd_issue ? rd_idx_q[ADDR_W-1:0] : '0;
  end

  always_comb begin
    state_d        = state_q;
    seq_len_d      = seq_len_q;
    snap_d         = snap_q;
    rd_idx_d       = rd_idx_q;
    inflight_d     = rd_issue;
    inflight_idx_d = rd_idx_q[ADDR_W-1:0];
    fifo_k_d       = fifo_k_q;
    fifo_v_d       = fifo_v_q;
    fifo_idx_d     = fifo_idx_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q + {1'b0, push} - {1'b0, pop};

    if (append_fire) begin
      seq_len_d = seq_len_q + LEN_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          snap_d   = seq_len_q;
          rd_idx_d = '0;
          state_d  = (seq_len_q == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (rd_issue) begin
          rd_idx_d = rd_idx_q + LEN_ONE;
        end
        if (pop && bus.out_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      fifo_k_d[wr_ptr_q]   = mem_k_rd;
      fifo_v_d[wr_ptr_q]   = mem_v_rd;
      fifo_idx_d[wr_ptr_q] = inflight_idx_q;
      wr_ptr_d             = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end

    // Clear wins over everything: drops the scan, queued entries and any read in flight.
    if (clear) begin
      state_d    = ST_IDLE;
      seq_len_d  = '0;
      snap_d     = '0;
      rd_idx_d   = '0;
      inflight_d = 1'b0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      cnt_d      = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      seq_len_q      <= '0;
      snap_q         <= '0;
      rd_idx_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      cnt_q          <= 2'd0;
    end else begin
      state_q        <= state_d;
      seq_len_q      <= seq_len_d;
      snap_q         <= snap_d;
      rd_idx_q       <= rd_idx_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
    end
  end

  // Payload storage needs no reset; outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    fifo_k_q   <= fifo_k_d;
    fifo_v_q   <= fifo_v_d;
    fifo_idx_q <= fifo_idx_d;
  end

endmodule

// File: tb/tb_kv_cache_sched.sv
// tb/tb_kv_cache_sched.sv - self-checking bench for kv_cache_sched
module tb_kv_cache_sched;
  localparam int DW = 16;
  localparam int DP = 256;

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] k;
    logic [15:0] v;
    logic        last;
  } exp_t;

  typedef struct {
    logic        av;
    logic [15:0] k;
    logic [15:0] v;
    logic        e_wr;
    logic [7:0]  e_addr;
    logic [8:0]  e_len;
  } vec_t;

  logic clk = 1'b0;
  logic rst, clear, scan_start;
  logic scan_busy, scan_done, full;
  logic [8:0] seq_len;
  logic mem_wr_en, mem_rd_en;
  logic [7:0] mem_wr_addr, mem_rd_addr;
  logic [15:0] mem_k_wr, mem_v_wr, mem_k_rd, mem_v_rd;

  kv_cache_sched_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  kv_cache_sched #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .clear(clear), .scan_start(scan_start),
    .scan_busy(scan_busy), .scan_done(scan_done), .seq_len(seq_len), .full(full),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_k_wr(mem_k_wr), .mem_v_wr(mem_v_wr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_k_rd(mem_k_rd), .mem_v_rd(mem_v_rd),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // kv_cache model: registered read, write-first
  logic [15:0] cache_k [DP];
  logic [15:0] cache_v [DP];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      cache_k[mem_wr_addr] <= mem_k_wr;
      cache_v[mem_wr_addr] <= mem_v_wr;
    end
    if (mem_rd_en) begin
      mem_k_rd <= (mem_wr_en && mem_wr_addr == mem_rd_addr) ? mem_k_wr : cache_k[mem_rd_addr];
      mem_v_rd <= (mem_wr_en && mem_wr_addr == mem_rd_addr) ? mem_v_wr : cache_v[mem_rd_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int done_base = 0;
  int m_len = 0;
  logic [15:0] ek [DP];
  logic [15:0] ev [DP];
  exp_t sb [$];
  vec_t tbl [6];
  logic rmode = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // out_ready: constant 1, or the repeating 1,0,0,1 stall pattern
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rmode ? pat[ph] : 1'b1;
      ph = (ph + 1) % 4;
    end
  end

  // Scoreboard monitor plus hold-while-stalled check
  logic stalled = 1'b0;
  logic [7:0] h_idx;
  logic [15:0] h_k, h_v;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (stalled) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_idx", 32'(bus.out_idx), 32'(h_idx));
        chk("stall_k", 32'(bus.out_k), 32'(h_k));
        chk("stall_v", 32'(bus.out_v), 32'(h_v));
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: idx=%0d with nothing pending at %0t", bus.out_idx, $time);
        end else begin
          e = sb.pop_front();
          chk("out_idx", 32'(bus.out_idx), 32'(e.idx));
          chk("out_k", 32'(bus.out_k), 32'(e.k));
          chk("out_v", 32'(bus.out_v), 32'(e.v));
          chk("out_last", 32'(bus.out_last), 32'(e.last));
        end
      end
      if (scan_done) done_cnt++;
    end
    stalled = !rst && !clear && bus.out_valid && !bus.out_ready;
    h_idx = bus.out_idx;
    h_k = bus.out_k;
    h_v = bus.out_v;
  end

  task automatic append_one(input logic [15:0] k, input logic [15:0] v);
    bus.append_valid = 1'b1;
    bus.append_k = k;
    bus.append_v = v;
    if (m_len < DP) begin
      ek[m_len] = k;
      ev[m_len] = v;
      m_len++;
    end
    tick();
    bus.append_valid = 1'b0;
  endtask

  task automatic start_scan();
    done_base = done_cnt;
    scan_start = 1'b1;
    for (int i = 0; i < m_len; i++)
      sb.push_back('{idx: 8'(i), k: ek[i], v: ev[i], last: (i == m_len - 1)});
    tick();
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int c;
    c = 0;
    while (done_cnt == done_base && c < limit) begin
      tick();
      c++;
    end
    chk("scan_done_seen", done_cnt - done_base, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb.delete();
    m_len = 0;
  endtask

  task automatic abort_mid_scan(input logic use_rst);
    int c, base, dbase;
    for (int i = 0; i < 6; i++) append_one(16'h500 + 16'(i), 16'h600 + 16'(i));
    base = out_cnt;
    start_scan();
    c = 0;
    while (out_cnt - base < 2 && c < 40) begin
      tick();
      c++;
    end
    chk("abort_two_out", 32'(out_cnt - base >= 2), 1);
    dbase = done_cnt;
    if (use_rst) rst = 1'b1; else clear = 1'b1;
    tick();
    rst = 1'b0;
    clear = 1'b0;
    sb.delete();
    m_len = 0;
    mid();
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_seq_len", 32'(seq_len), 0);
    chk("abort_busy", 32'(scan_busy), 0);
    chk("abort_ready", 32'(bus.append_ready), 1);
    repeat (6) tick();
    chk("abort_no_done", done_cnt - dbase, 0);
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    scan_start = 1'b0;
    bus.append_valid = 1'b0;
    bus.append_k = '0;
    bus.append_v = '0;

    for (int i = 0; i < 5; i++)
      tbl[i] = '{av: 1'b1, k: 16'h100 + 16'(i), v: 16'h200 + 16'(i), e_wr: 1'b1, e_addr: 8'(i), e_len: 9'(i)};
    tbl[5] = '{av: 1'b0, k: 16'h0, v: 16'h0, e_wr: 1'b0, e_addr: 8'h0, e_len: 9'd5};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mid();
    chk("rst_seq_len", 32'(seq_len), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_append_ready", 32'(bus.append_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(scan_busy), 0);
    chk("rst_done", 32'(scan_done), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    tick();

    for (int i = 0; i < 6; i++) begin
      bus.append_valid = tbl[i].av;
      bus.append_k = tbl[i].k;
      bus.append_v = tbl[i].v;
      mid();
      chk("tbl_wr_en", 32'(mem_wr_en), 32'(tbl[i].e_wr));
      chk("tbl_seq_len", 32'(seq_len), 32'(tbl[i].e_len));
      chk("tbl_ready", 32'(bus.append_ready), 1);
      if (tbl[i].e_wr) begin
        chk("tbl_wr_addr", 32'(mem_wr_addr), 32'(tbl[i].e_addr));
        chk("tbl_wr_k", 32'(mem_k_wr), 32'(tbl[i].k));
        chk("tbl_wr_v", 32'(mem_v_wr), 32'(tbl[i].v));
      end
      if (tbl[i].av) begin
        ek[m_len] = tbl[i].k;
        ev[m_len] = tbl[i].v;
        m_len++;
      end
      tick();
    end
    bus.append_valid = 1'b0;

    // Five-entry scan: outputs in cycles 3..7, scan_done in cycle 8
    start_scan();
    for (int c = 1; c <= 9; c++) begin
      mid();
      chk("t1_out_valid", 32'(bus.out_valid), 32'(c >= 3 && c <= 7));
      chk("t1_scan_done", 32'(scan_done), 32'(c == 8));
      chk("t1_busy", 32'(scan_busy), 32'(c <= 8));
      if (c == 1) begin
        chk("t1_rd_en", 32'(mem_rd_en), 1);
        chk("t1_rd_addr", 32'(mem_rd_addr), 0);
      end
      tick();
    end
    chk("t1_sb_drained", sb.size(), 0);

    // Eight entries under the 1,0,0,1 stall pattern
    for (int i = 5; i < 8; i++) append_one(16'h100 + 16'(i), 16'h200 + 16'(i));
    rmode = 1'b1;
    start_scan();
    wait_done(200);
    rmode = 1'b0;
    tick();

    // Snapshot of 4 while appending every cycle during the scan
    do_clear();
    for (int i = 0; i < 4; i++) append_one(16'h300 + 16'(i), 16'h400 + 16'(i));
    start_scan();
    for (int i = 4; i < 10; i++) append_one(16'h300 + 16'(i), 16'h400 + 16'(i));
    wait_done(50);
    mid();
    chk("t3_seq_len", 32'(seq_len), 10);
    tick();
    start_scan();
    wait_done(80);

    // Empty scan
    do_clear();
    start_scan();
    mid();
    chk("t4_done", 32'(scan_done), 1);
    chk("t4_out_valid", 32'(bus.out_valid), 0);
    tick();
    mid();
    chk("t4_done_off", 32'(scan_done), 0);
    chk("t4_busy_off", 32'(scan_busy), 0);
    tick();

    do_clear();
    abort_mid_scan(1'b0);
    abort_mid_scan(1'b1);

    // Fill to DEPTH, blocked append, full-length scan
    for (int i = 0; i < DP; i++) append_one(16'(i * 3 + 1), ~16'(i));
    mid();
    chk("t6_full", 32'(full), 1);
    chk("t6_ready", 32'(bus.append_ready), 0);
    chk("t6_seq_len", 32'(seq_len), DP);
    tick();
    bus.append_valid = 1'b1;
    bus.append_k = 16'hdead;
    bus.append_v = 16'hbeef;
    mid();
    chk("t6_no_write", 32'(mem_wr_en), 0);
    tick();
    bus.append_valid = 1'b0;
    mid();
    chk("t6_seq_len_hold", 32'(seq_len), DP);
    tick();
    start_scan();
    wait_done(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kv_cache_sched.md
# kv_cache_sched

Sequencing controller for the per-head `kv_cache` memory (DEPTH × {K,V}, 1-cycle registered read, write-first). Accepts one new token's K/V per cycle and appends it at the current sequence length. On request it streams all cached entries, index 0 to len−1, to the attention datapath over a valid/ready interface with full backpressure. Sits between the token projection stage (append side), the attention score/softmax pipeline (scan side) and one `kv_cache` instance.

## Interface
- `DATA_WIDTH`, 16, width of each K and V element
- `DEPTH`, 256, cache entries (power of two, ≥ 4); `ADDR_W` = $clog2(DEPTH)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `clear`  in  1  pulse: empty the cache (len←0), abort any scan
- `append_valid` / `append_ready`  in / out  1  append handshake; `append_ready` = !full
- `append_k`, `append_v`  in  DATA_WIDTH  token K/V
- `scan_start`  in  1  pulse: begin streaming snapshot of current length
- `scan_busy`  out  1  scan in progress
- `scan_done`  out  1  one-cycle pulse at scan completion
- `out_valid` / `out_ready`  out / in  1  scan output handshake
- `out_k`, `out_v`  out  DATA_WIDTH  streamed entry
- `out_idx`  out  ADDR_W  entry index; `out_last`  out  1  idx == snapshot−1
- `seq_len`  out  ADDR_W+1  entries stored (0..DEPTH); `full`  out  1  seq_len == DEPTH
- `mem_wr_en`, `mem_wr_addr`[ADDR_W], `mem_k_wr`, `mem_v_wr`  out  cache write port
- `mem_rd_en`, `mem_rd_addr`[ADDR_W]  out  cache read port
- `mem_k_rd`, `mem_v_rd`  in  DATA_WIDTH  read data, valid the cycle after `mem_rd_en`

## Operation
- Reset / clear: seq_len=0, state IDLE, skid FIFO empty, all outputs 0 except `append_ready`=1. `clear` has priority over append and scan in the same cycle; an aborted scan emits no `scan_done`; in-flight read data is discarded.
- Append: on `append_valid && append_ready`, same cycle drive `mem_wr_en`=1, `mem_wr_addr`=seq_len[ADDR_W-1:0], data passthrough; seq_len increments at the edge. Appends are allowed in every state, including during a scan.
- Full: seq_len==DEPTH ⇒ `append_ready`=0, no write, no wrap-around.
- States: IDLE → (scan_start, seq_len>0) → SCAN → (last element handshaken) → DONE (1 cycle, `scan_done`=1) → IDLE. scan_start with seq_len==0 → DONE directly. scan_start outside IDLE is ignored.
- Snapshot: SCAN latches n=seq_len at acceptance; later appends do not extend the scan. Scan addresses < n ≤ write address, so no read/write collision.
- Read issue: 2-entry skid FIFO of {k,v,idx}. Issue `mem_rd_en` with `mem_rd_addr`=rd_idx when rd_idx<n and (FIFO occupancy after this cycle's pop + in-flight) < 2. Returned data is pushed the cycle after issue. `out_*` is driven from the FIFO head.
- `scan_busy`=1 in SCAN and DONE.

## Timing
- Append: write issued the same cycle as the handshake; `seq_len` updates next cycle. Throughput is 1 per cycle.
- Scan: scan_start sampled in cycle 0 → first `mem_rd_en` in cycle 1 → `out_valid` in cycle 3. With `out_ready`=1 throughout, entry i is presented in cycle 3+i, the last in cycle 2+n, and `scan_done` pulses in cycle 3+n.
- Backpressure: `out_*` holds stable while `out_valid && !out_ready`. No entry is lost or duplicated, and the FIFO never overflows.
- DEPTH case: a scan of n=DEPTH must terminate. Use an ADDR_W+1 bit rd_idx.

## Test plan
- Reset, then append 5 entries (k=0x100+i, v=0x200+i), then scan with out_ready=1 → out_valid in cycles 3..7, idx 0..4 with matching data, out_last only at idx 4, scan_done in cycle 8.
- Scan of 8 entries with out_ready toggling 1,0,0,1,… → every idx 0..7 delivered exactly once, in order, with data stable while stalled.
- Append DEPTH entries → full=1, append_ready=0, a further append_valid produces no mem_wr_en; a scan of 256 entries completes with idx 255 flagged last.
- Scan started at seq_len=4 with appends every cycle during the scan → exactly 4 outputs; seq_len reaches 4+appends; a second scan returns all entries.
- scan_start at seq_len=0 → no out_valid, scan_done exactly 1 cycle later.
- clear asserted mid-scan (after 2 of 6 outputs) → out_valid drops next cycle, no scan_done, seq_len=0, scan_busy=0. Same check with rst.
